// File: rtl/i2c_cfg_arbiter.sv
// Round-robin arbiter that shares one I2C configuration controller among four requesters.
// Optional feature macro: I2C_ARB_RETRY_EN (retry a NACKed transfer up to MAX_RETRY extra times).
module i2c_cfg_arbiter #(
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [3:0]  iREQ,
    input  logic [95:0] iDATA,
    output logic [3:0]  oGNT,
    output logic [3:0]  oDONE,
    output logic [3:0]  oERR,
    output logic [23:0] oI2C_DATA,
    output logic        oI2C_GO,
    input  logic        iI2C_END,
    input  logic        iI2C_ACK,
    output logic        oBUSY
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP, DONE} state_t;

    localparam logic [15:0] ToLimit = 16'(TIMEOUT_CYC);

    state_t      state, stateNxt;
    logic [1:0]  last, lastNxt, winner;
    logic [3:0]  gntNxt, doneNxt, errNxt;
    logic [23:0] dataNxt;
    logic        goNxt;
    logic [15:0] toCnt, toCntNxt, toInc;
    logic        nack, nackNxt, tmo, tmoNxt;
    logic        retryOk;

    assign oBUSY = (state != IDLE);
    assign toInc = (toCnt == 16'hFFFF) ? toCnt : toCnt + 16'd1;

    // Scan from the highest offset down so the nearest requester after 'last' wins.
    always_comb begin
        winner = last;
        for (int i = 4; i >= 1; i--) begin
            if (iREQ[last + 2'(i)]) winner = last + 2'(i);
        end
    end

`ifdef I2C_ARB_RETRY_EN
    localparam int RetryW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RetryW-1:0] retryCnt;

    assign retryOk = nack && !tmo && (32'(retryCnt) < 32'(MAX_RETRY));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            retryCnt <= '0;
        end else if (state == IDLE) begin
            retryCnt <= '0;
        end else if (state == DROP && !iI2C_END && retryOk) begin
            retryCnt <= retryCnt + RetryW'(1);
        end
    end
`else
    assign retryOk = 1'b0;
`endif

    always_comb begin
        stateNxt = state;
        gntNxt   = oGNT;
        doneNxt  = '0;
        errNxt   = '0;
        dataNxt  = oI2C_DATA;
        goNxt    = oI2C_GO;
        lastNxt  = last;
        toCntNxt = toCnt;
        nackNxt  = nack;
        tmoNxt   = tmo;
        case (state)
            IDLE: begin
                if (|iREQ) begin
                    stateNxt = WAIT;
                    gntNxt   = 4'b0001 << winner;
                    dataNxt  = iDATA[24*winner +: 24];
                    goNxt    = 1'b1;
                    lastNxt  = winner;
                    toCntNxt = '0;
                    nackNxt  = 1'b0;
                    tmoNxt   = 1'b0;
                end
            end
            WAIT: begin
                toCntNxt = toInc;
                // A controller END in the same cycle as the limit still counts as a real answer.
                if (iI2C_END) begin
                    nackNxt  = iI2C_ACK;
                    goNxt    = 1'b0;
                    stateNxt = DROP;
                end else if (toInc >= ToLimit) begin
                    tmoNxt   = 1'b1;
                    goNxt    = 1'b0;
                    stateNxt = DROP;
                end
            end
            DROP: begin
                if (!iI2C_END) begin
                    if (retryOk) begin
                        stateNxt = WAIT;
                        goNxt    = 1'b1;
                        toCntNxt = '0;
                        nackNxt  = 1'b0;
                    end else begin
                        stateNxt = DONE;
                        doneNxt  = oGNT;
                        errNxt   = (nack || tmo) ? oGNT : 4'b0000;
                    end
                end
            end
            DONE: begin
                stateNxt = IDLE;
                gntNxt   = '0;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= IDLE;
            oGNT      <= '0;
            oDONE     <= '0;
            oERR      <= '0;
            oI2C_DATA <= '0;
            oI2C_GO   <= 1'b0;
            last      <= 2'd3;
            toCnt     <= '0;
            nack      <= 1'b0;
            tmo       <= 1'b0;
        end else begin
            state     <= stateNxt;
            oGNT      <= gntNxt;
            oDONE     <= doneNxt;
            oERR      <= errNxt;
            oI2C_DATA <= dataNxt;
            oI2C_GO   <= goNxt;
            last      <= lastNxt;
            toCnt     <= toCntNxt;
            nack      <= nackNxt;
            tmo       <= tmoNxt;
        end
    end
endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Scoreboard bench for i2c_cfg_arbiter: random requests against a round-robin reference model
// and a behavioural I2C controller; honours I2C_ARB_RETRY_EN in the same way as the design.
`timescale 1ns/1ps
module tb_i2c_cfg_arbiter;
    localparam int MaxRetry   = 3;
    localparam int TimeoutCyc = 20;
`ifdef I2C_ARB_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b1;
    logic [3:0]  iREQ = '0;
    logic [95:0] iDATA = '0;
    logic        iI2C_END = 1'b0;
    logic        iI2C_ACK = 1'b0;
    logic [3:0]  oGNT, oDONE, oERR;
    logic [23:0] oI2C_DATA;
    logic        oI2C_GO, oBUSY;

    i2c_cfg_arbiter #(.MAX_RETRY(MaxRetry), .TIMEOUT_CYC(TimeoutCyc)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ), .iDATA(iDATA),
        .oGNT(oGNT), .oDONE(oDONE), .oERR(oERR), .oI2C_DATA(oI2C_DATA),
        .oI2C_GO(oI2C_GO), .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int          owner;
        logic [23:0] data;
        bit          err;
        bit          tmo;
        int          pulses;
    } exp_t;

    exp_t        sb[$];
    int          nChecks = 0;
    int          nFails = 0;
    logic [3:0]  reqMask = '0;
    logic [23:0] reqData [4];
    int          lastW = 3;

    // Controller behaviour for the current transaction
    int latency = 5;
    int nackLeft = 0;
    bit noResp = 1'b0;
    int endHold = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pickWinner(input logic [3:0] m, input int lastIdx);
        for (int i = 1; i <= 4; i++) begin
            if (m[(lastIdx + i) % 4]) return (lastIdx + i) % 4;
        end
        return -1;
    endfunction

    task automatic raiseBits(input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[k] && !reqMask[k]) begin
                reqData[k] = 24'($urandom);
                iDATA[24*k +: 24] = reqData[k];
                reqMask[k] = 1'b1;
            end
        end
        iREQ = reqMask;
    endtask

    task automatic doReset();
        iRST_N = 1'b0;
        reqMask = '0;
        iREQ = '0;
        sb.delete();
        lastW = 3;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_gnt", oGNT, 0);
        chk("rst_done", oDONE, 0);
        chk("rst_err", oERR, 0);
        chk("rst_go", oI2C_GO, 0);
        chk("rst_data", oI2C_DATA, 0);
        chk("rst_busy", oBUSY, 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
    endtask

    task automatic doTrans(input logic [3:0] raise, input logic [3:0] midRaise, input bit midDrop,
                           input int lat, input int nacks, input bit tmo, input int hold,
                           input bit chkNext);
        exp_t e;
        int   w;
        bit   seen;
        latency  = lat;
        nackLeft = nacks;
        noResp   = tmo;
        endHold  = hold;
        raiseBits(raise);
        w = pickWinner(reqMask, lastW);
        if (w < 0) return;
        e.owner = w;
        e.data  = reqData[w];
        e.tmo   = tmo;
        if (tmo) begin
            e.pulses = 1; e.err = 1'b1;
        end else if (RetryEn) begin
            e.pulses = (nacks > MaxRetry) ? MaxRetry + 1 : nacks + 1;
            e.err    = (nacks > MaxRetry);
        end else begin
            e.pulses = 1; e.err = (nacks > 0);
        end
        sb.push_back(e);
        lastW = w;
        if (chkNext) begin
            @(posedge iCLK);
            #1;
            chk("next_gnt", oGNT, 1 << w);
            chk("next_data", oI2C_DATA, reqData[w]);
            chk("next_go", oI2C_GO, 1);
        end
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge iCLK);
            if (oDONE != 0) seen = 1'b1;
            if (c == 4) begin
                raiseBits(midRaise);
                if (midDrop) reqMask[w] = 1'b0;
                iREQ = reqMask;
            end
        end
        chk("done_seen", seen, 1);
        @(posedge iCLK);
        #1;
        reqMask[w] = 1'b0;
        iREQ = reqMask;
    endtask

    task automatic drain();
        while (reqMask != 0) doTrans(4'b0000, 4'b0000, 1'b0, $urandom_range(1, 6), 0, 1'b0, 0, 1'b0);
    endtask

    // Behavioural controller: END after 'latency' cycles, held 'endHold' cycles past GO falling.
    initial begin : ctrl
        int st, cnt;
        st = 0; cnt = 0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                st = 0; iI2C_END = 1'b0; iI2C_ACK = 1'b0;
            end else begin
                case (st)
                    0: if (oI2C_GO && !iI2C_END) begin cnt = 0; st = 1; end
                    1: begin
                        if (!oI2C_GO) st = 0;
                        else if (!noResp) begin
                            cnt++;
                            if (cnt >= latency) begin
                                iI2C_END = 1'b1;
                                iI2C_ACK = (nackLeft > 0);
                                if (nackLeft > 0) nackLeft--;
                                st = 2;
                            end
                        end
                    end
                    2: if (!oI2C_GO) begin cnt = 0; st = 3; end
                    default: begin
                        if (cnt >= endHold) begin
                            iI2C_END = 1'b0; iI2C_ACK = 1'b0; st = 0;
                        end else cnt++;
                    end
                endcase
            end
        end
    end

    initial begin : mon
        logic prevGo;
        int   goCnt, riseCyc;
        exp_t e;
        prevGo = 1'b0; goCnt = 0; riseCyc = 0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                prevGo = 1'b0; goCnt = 0;
            end else begin
                chk("gnt_onehot", $onehot0(oGNT), 1);
                chk("done_onehot", $onehot0(oDONE), 1);
                chk("err_onehot", $onehot0(oERR), 1);
                chk("err_without_done", oERR & ~oDONE, 0);
                chk("busy_vs_gnt", oBUSY, |oGNT);
                if (oBUSY && sb.size() != 0) chk("gnt_hold", oGNT, 1 << sb[0].owner);
                if (oI2C_GO && !prevGo) begin
                    chk("pending_at_go", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb[0];
                        chk("go_gnt", oGNT, 1 << e.owner);
                        chk("go_data", oI2C_DATA, e.data);
                        chk("go_end_low", iI2C_END, 0);
                        goCnt++;
                        riseCyc = cyc;
                    end
                end
                if (!oI2C_GO && prevGo && sb.size() != 0 && sb[0].tmo)
                    chk("tmo_go_width", cyc - riseCyc, TimeoutCyc);
                if (oDONE != 0) begin
                    chk("pending_at_done", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("done_owner", oDONE, 1 << e.owner);
                        chk("done_err", oERR, e.err ? (1 << e.owner) : 0);
                        chk("go_pulses", goCnt, e.pulses);
                    end
                    goCnt = 0;
                end
                prevGo = oI2C_GO;
            end
        end
    end

    initial begin : watchdog
        #(2000000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        doReset();

        // Single requester, acked after 10 cycles
        reqData[0] = 24'h729803;
        iDATA[23:0] = reqData[0];
        reqMask[0] = 1'b1;
        iREQ = reqMask;
        doTrans(4'b0000, 4'b0000, 1'b0, 10, 0, 1'b0, 2, 1'b1);

        // Reset in WAIT abandons the transfer; priority restarts at requester 0
        raiseBits(4'b0010);
        latency = 5; nackLeft = 0; noResp = 1'b1; endHold = 0;
        begin
            exp_t e;
            e.owner = pickWinner(reqMask, lastW);
            e.data = reqData[1]; e.tmo = 1'b1; e.err = 1'b1; e.pulses = 1;
            sb.push_back(e);
        end
        for (int c = 0; c < 20 && !oI2C_GO; c++) @(negedge iCLK);
        chk("rst_go_up", oI2C_GO, 1);
        repeat (3) @(negedge iCLK);
        #2 iRST_N = 1'b0;
        #1;
        chk("async_rst_gnt", oGNT, 0);
        chk("async_rst_done", oDONE, 0);
        chk("async_rst_err", oERR, 0);
        chk("async_rst_go", oI2C_GO, 0);
        chk("async_rst_data", oI2C_DATA, 0);
        chk("async_rst_busy", oBUSY, 0);
        sb.delete(); reqMask = '0; iREQ = '0; lastW = 3;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
        doTrans(4'b1001, 4'b0000, 1'b0, 3, 0, 1'b0, 0, 1'b0);
        drain();

        // All four held and re-raised after each completion
        doReset();
        doTrans(4'b1111, 4'b0000, 1'b0, 2, 0, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 4; i++)
            doTrans(4'b0000, 4'b0001 << ((i - 1) % 4), 1'b0, 2, 0, 1'b0, 0, 1'b0);
        drain();

        // NACK on every attempt, then timeout, then END held long after a NACK and an ACK
        doTrans(4'b0100, 4'b0000, 1'b0, 4, 9, 1'b0, 1, 1'b0);
        doTrans(4'b1000, 4'b0000, 1'b0, 4, 0, 1'b1, 0, 1'b0);
        doTrans(4'b0010, 4'b0000, 1'b0, 3, 1, 1'b0, 8, 1'b0);
        doTrans(4'b0001, 4'b0000, 1'b0, 3, 0, 1'b0, 8, 1'b0);
        drain();

        for (int n = 0; n < 60; n++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            if ((r | reqMask) == 0) r = 4'b0001 << $urandom_range(0, 3);
            doTrans(r, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                    $urandom_range(1, 15),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
                    ($urandom_range(0, 9) == 0), $urandom_range(0, 3), 1'b0);
        end
        drain();

        repeat (5) @(negedge iCLK);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
